// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and default widths for the chunked adder/subtractor
package addsub_pkg;
  localparam int W_DEF = 32;
  localparam int K_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: K-bit combinational adder slice with carry in/out
module addsub_slice import addsub_pkg::*; #(
  parameter int K = K_DEF
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         ci,
  output logic [K-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + (K+1)'(ci);
endmodule

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: W-bit add/sub computed one K-bit chunk per cycle through a single reused slice
module addsub_seq_ctrl import addsub_pkg::*; #(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);
  localparam int M = W / K;
  localparam int IW = $clog2(M);
  state_t state, state_nx;
  logic [W-1:0] a_r, b_r;
  logic carry;
  logic [IW-1:0] idx;
  logic [K-1:0] s;
  logic co, last, accept;
  assign accept = in_valid && in_ready;
  assign last = idx == IW'(M - 1);
  addsub_slice #(.K(K)) u_slice (
    .x (a_r[idx*K +: K]),
    .y (b_r[idx*K +: K]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: accept -> run M chunks -> hold until consumed
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? RUN :
               (state == RUN && last)      ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  // handshake and status outputs decoded from state
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  // operand capture and chunked accumulation; flags taken from the top chunk
  always_ff @(posedge clk)
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b ^ {W{sub}};
      carry <= sub;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      sum[idx*K +: K] <= s;
      carry <= co;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout <= co;
        ovf  <= (a_r[W-1] == b_r[W-1]) && (s[K-1] != a_r[W-1]);
      end
    end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl: directed self-checking bench for the chunked add/sub controller
module tb_addsub_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [31:0] a = '0, b = '0, sum, held;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  addsub_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] ym;
    logic [32:0] r;
    ym = s ? ~y : y;
    r = {1'b0, x} + {1'b0, ym} + 33'(s);
    return {r[32], (x[31] == ym[31]) && (r[31] != x[31]), r[31:0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_accept(input logic [31:0] x, input logic [31:0] y, input logic s);
    chk("pre_accept_ready", in_ready, 1);
    a = x; b = y; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
  endtask
  task automatic wait_valid(input string tag);
    int c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    chk(tag, c, 4);
  endtask
  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] es, input logic ec, input logic eo);
    do_accept(x, y, s);
    wait_valid({tag, "_lat"});
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    consume();
    chk({tag, "_kept"}, sum, es);
  endtask
  initial begin
    logic [33:0] q[$];
    logic [33:0] e;
    int last_acc, n_acc;
    bit seen;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_sum", sum, 0);
    chk("rst_flags", {out_valid, busy, cout, ovf}, 0);
    chk("rst_ready", in_ready, 1);
    run_op("ff_plus_1", 32'h000000FF, 32'h1, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("5_minus_7", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("7_minus_5", 32'd7, 32'd5, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run_op("maxpos_p1", 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("allone_p1", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("minneg_m1", 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    do_accept(32'h12345678, 32'h11111111, 1'b0);
    wait_valid("hold_lat");
    held = sum;
    chk("hold_sum0", held, 32'h23456789);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 32'h0000_0100 + i; b = 32'h1; sub = 1'b0;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, held);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    consume();
    chk("hold_no_accept", busy, 0);
    tick();
    chk("hold_still_idle", busy, 0);
    chk("hold_retained", sum, held);
    do_accept(32'hDEADBEEF, 32'h01010101, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sum", sum, 0);
    chk("abort_flags", {out_valid, busy, cout, ovf}, 0);
    chk("abort_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("abort_no_valid", seen, 0);
    run_op("post_abort", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_acc = -1;
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      a = $urandom; b = $urandom; sub = c[1];
      if (out_valid) begin
        chk("stream_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("stream_sum", sum, e[31:0]);
          chk("stream_flags", {cout, ovf}, e[33:32]);
        end
      end
      if (in_ready) begin
        q.push_back(model(a, b, sub));
        if (last_acc >= 0) chk("stream_spacing", c - last_acc, 6);
        last_acc = c;
        n_acc++;
      end
      tick();
    end
    chk("stream_accepts", n_acc, 7);
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
